// File: rtl/lfsr_rng_gen.sv
// Fibonacci LFSR word generator with valid/ready output, runtime seed load and STEP shifts per word.
// Optional period counter / wrap pulse outputs are built when LFSR_PERIOD_CNT_EN is defined.
module lfsr_rng_gen #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(5'b10100),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(5'b00001),
  parameter int               OUT_W = WIDTH,
  parameter int               STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_data,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [WIDTH-1:0] period_cnt,
  output logic             wrap_pulse
`endif
);

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] SEED_G = (SEED == '0) ? ONE : SEED;

  logic [WIDTH-1:0] state, adv, nxt, nxt_g, seed_g;
  logic             hs;

  // STEP single shifts unrolled into one combinational advance
  always_comb begin
    adv = state;
    for (int i = 0; i < STEP; i++)
      adv = {adv[WIDTH-2:0], ^(adv & TAPS)};
  end

  assign hs       = out_valid & out_ready;
  assign seed_g   = (seed_data == '0) ? ONE : seed_data;
  assign nxt      = hs ? adv : state;
  assign nxt_g    = (nxt == '0) ? ONE : nxt;
  assign out_data = state[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED_G;
      out_valid <= 1'b0;
    end else if (seed_load) begin
      state     <= seed_g;
      out_valid <= 1'b0;
    end else begin
      state     <= nxt_g;
      out_valid <= en;
    end
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] last_seed;

  // wrap is detected when an accepted word brings the state back to the last seed
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      wrap_pulse <= 1'b0;
      last_seed  <= SEED_G;
    end else if (seed_load) begin
      period_cnt <= '0;
      wrap_pulse <= 1'b0;
      last_seed  <= seed_g;
    end else begin
      wrap_pulse <= 1'b0;
      if (hs) begin
        if (nxt_g == last_seed) begin
          period_cnt <= '0;
          wrap_pulse <= 1'b1;
        end else begin
          period_cnt <= period_cnt + 1'b1;
        end
      end
    end
  end
`else
  // core only: no period tracking
`endif

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Directed bench for lfsr_rng_gen: default instance plus a STEP=2 instance sharing the same stimulus.
module tb_lfsr_rng_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       seed_load = 1'b0;
  logic [4:0] seed_data = 5'h00;
  logic       out_ready = 1'b0;
  logic [4:0] dout, dout2;
  logic       vld, vld2;
`ifdef LFSR_PERIOD_CNT_EN
  logic [4:0] pcnt, pcnt2;
  logic       wrap, wrap2;
`endif

  int total = 0;
  int bad = 0;

  lfsr_rng_gen u_dut (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_data(seed_data),
    .out_data(dout), .out_valid(vld), .out_ready(out_ready)
`ifdef LFSR_PERIOD_CNT_EN
    , .period_cnt(pcnt), .wrap_pulse(wrap)
`endif
  );

  lfsr_rng_gen #(.STEP(2)) u_s2 (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_data(seed_data),
    .out_data(dout2), .out_valid(vld2), .out_ready(out_ready)
`ifdef LFSR_PERIOD_CNT_EN
    , .period_cnt(pcnt2), .wrap_pulse(wrap2)
`endif
  );

  always #5 clk = ~clk;

  // x^5+x^2+1 single step, straight from the polynomial
  function automatic logic [4:0] f_step(input logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; out_ready = 1'b0; seed_load = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; out_ready = 1'b1;
    tick(); tick();
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", vld); end
    total++;
    if (dout !== 5'h01) begin bad++; $display("FAIL reset_data got=%h exp=01", dout); end
  endtask

  task automatic test_sequence();
    logic [4:0] exp7 [7];
    logic [4:0] m;
    exp7 = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B};
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if (vld !== 1'b1 || dout !== exp7[i]) begin
        bad++; $display("FAIL seq[%0d] got=%b/%h exp=1/%h", i, vld, dout, exp7[i]);
      end
    end
    m = 5'h0B;
    for (int i = 7; i < 31; i++) begin
      tick();
      m = f_step(m);
      total++;
      if (dout !== m) begin bad++; $display("FAIL seq_model[%0d] got=%h exp=%h", i, dout, m); end
    end
    tick();
    total++;
    if (dout !== 5'h01) begin bad++; $display("FAIL seq_wrap31 got=%h exp=01", dout); end
  endtask

  task automatic test_stall();
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    tick(); tick();
    total++;
    if (dout !== 5'h02) begin bad++; $display("FAIL stall_pre got=%h exp=02", dout); end
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (dout !== 5'h02 || vld !== 1'b1) begin
        bad++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/02", i, vld, dout);
      end
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (dout !== 5'h04) begin bad++; $display("FAIL stall_resume got=%h exp=04", dout); end
  endtask

  task automatic test_seed_load();
    logic [4:0] exp_d [6];
    logic       exp_v [6];
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick();
    total++;
    if (dout !== 5'h04) begin bad++; $display("FAIL seed_pre got=%h exp=04", dout); end
    exp_d = '{5'h01, 5'h01, 5'h02, 5'h12, 5'h12, 5'h05};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      seed_load = (i == 0 || i == 3);
      seed_data = (i == 3) ? 5'h12 : 5'h00;
      tick();
      total++;
      if (vld !== exp_v[i] || dout !== exp_d[i]) begin
        bad++; $display("FAIL seed[%0d] got=%b/%h exp=%b/%h", i, vld, dout, exp_v[i], exp_d[i]);
      end
    end
    seed_load = 1'b0; seed_data = 5'h00;
  endtask

  task automatic test_step2();
    logic [4:0] exp4 [4];
    exp4 = '{5'h01, 5'h04, 5'h12, 5'h0B};
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (vld2 !== 1'b1 || dout2 !== exp4[i]) begin
        bad++; $display("FAIL step2[%0d] got=%b/%h exp=1/%h", i, vld2, dout2, exp4[i]);
      end
    end
  endtask

  task automatic test_en_low();
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    tick(); tick();
    en = 1'b0;
    tick();
    total++;
    if (vld !== 1'b0 || dout !== 5'h04) begin
      bad++; $display("FAIL en_drop got=%b/%h exp=0/04", vld, dout);
    end
    tick(); tick();
    total++;
    if (dout !== 5'h04) begin bad++; $display("FAIL en_frozen got=%h exp=04", dout); end
  endtask

  task automatic test_rst_midstream();
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    total++;
    if (dout !== 5'h16) begin bad++; $display("FAIL mid_pre got=%h exp=16", dout); end
    rst = 1'b1;
    tick();
    total++;
    if (vld !== 1'b0 || dout !== 5'h01) begin
      bad++; $display("FAIL mid_rst got=%b/%h exp=0/01", vld, dout);
    end
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (vld !== 1'b0 || dout !== 5'h01) begin
        bad++; $display("FAIL mid_enlow[%0d] got=%b/%h exp=0/01", i, vld, dout);
      end
    end
    en = 1'b1;
    tick();
    total++;
    if (vld !== 1'b1 || dout !== 5'h01) begin
      bad++; $display("FAIL mid_restart got=%b/%h exp=1/01", vld, dout);
    end
    tick();
    total++;
    if (dout !== 5'h02) begin bad++; $display("FAIL mid_next got=%h exp=02", dout); end
  endtask

`ifdef LFSR_PERIOD_CNT_EN
  task automatic test_period();
    int acc;
    logic ew;
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      acc = k - 1;
      ew = (acc > 0) && (acc % 31 == 0);
      total++;
      if (pcnt !== 5'(acc % 31) || wrap !== ew) begin
        bad++; $display("FAIL period[%0d] got=%0d/%b exp=%0d/%b", k, pcnt, wrap, acc % 31, ew);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_seed_load();
    test_step2();
    test_en_low();
    test_rst_midstream();
`ifdef LFSR_PERIOD_CNT_EN
    test_period();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
